// File: rtl/mdu_iter_if.sv
// ============================================================================
// mdu_iter_if : issue/result bundle between control and the iterative MDU
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, hi_o, lo_o
  );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mdu_iter_if.slave  bus
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     opb_q;
  logic                 div_q;
  logic                 neg_q;
  logic                 rneg_q;
  logic                 dz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;

  // Issue-side operand conditioning
  logic                 sgn_d;
  logic                 a_neg_d;
  logic                 b_neg_d;
  logic [WIDTH-1:0]     a_mag_d;
  logic [WIDTH-1:0]     b_mag_d;

  always_comb begin
    sgn_d   = ~bus.op_i[0];
    a_neg_d = sgn_d & bus.a_i[WIDTH-1];
    b_neg_d = sgn_d & bus.b_i[WIDTH-1];
    a_mag_d = a_neg_d ? (~bus.a_i + 1'b1) : bus.a_i;
    b_mag_d = b_neg_d ? (~bus.b_i + 1'b1) : bus.b_i;
  end

  // One iteration step; acc_q holds {hi_part, lo_part} for both multiply
  // (partial product / multiplier) and divide (remainder / quotient).
  logic [WIDTH:0]       sum_d;
  logic [WIDTH:0]       shl_d;
  logic [WIDTH:0]       diff_d;

  always_comb begin
    sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    shl_d  = acc_q[2*WIDTH-1:WIDTH-1];
    diff_d = shl_d - {1'b0, opb_q};
    acc_d  = acc_q;
    if (div_q) begin
      if (!diff_d[WIDTH]) begin
        acc_d = {diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {shl_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else if (acc_q[0]) begin
      acc_d = {sum_d, acc_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Sign fix-up of the magnitude result
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     rem_d;

  always_comb begin
    prod_d = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_d  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_d  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      quo_d = '1;
    end
    if (div_q) begin
      hi_d = rem_d;
      lo_d = quo_d;
    end else begin
      hi_d = prod_d[2*WIDTH-1:WIDTH];
      lo_d = prod_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.op_i == OP_MTHI) begin
              hi_q <= bus.a_i;
            end else if (bus.op_i == OP_MTLO) begin
              lo_q <= bus.a_i;
            end else if (!bus.op_i[2]) begin
              // Multiply shifts the multiplier out of the low half; divide
              // shifts the dividend out of it, so both load the same way.
              acc_q   <= {{WIDTH{1'b0}}, bus.op_i[1] ? a_mag_d : b_mag_d};
              opb_q   <= bus.op_i[1] ? b_mag_d : a_mag_d;
              div_q   <= bus.op_i[1];
              neg_q   <= a_neg_d ^ b_neg_d;
              rneg_q  <= a_neg_d;
              dz_q    <= bus.op_i[1] && (bus.b_i == '0);
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = (state_q != S_IDLE);
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// Randomized bench for mdu_iter: a cycle-level reference model built on
// native 64-bit arithmetic, compared against the DUT on every falling edge.
`default_nettype none

module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_hi, m_lo;
  logic [63:0]  m_pend;
  int           m_left;

  // Literal-check request from the stimulus process
  bit           armed = 1'b0;
  bit           lit_valid = 1'b0;
  bit           lit_tmo;
  logic [W-1:0] lit_hi, lit_lo;
  string        lit_name;

  function automatic logic [63:0] ref_result(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = ua * ub;
      3'd2: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model: an issued op occupies the unit for W+1 edges, then lands in HI/LO.
  initial begin
    m_hi = '0; m_lo = '0; m_pend = '0; m_left = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_hi = '0; m_lo = '0; m_left = 0;
      end else if (m_left != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = m_pend[63:32];
          m_lo = m_pend[31:0];
        end
      end else if (bus.start_i) begin
        if (bus.op_i < 3'd4) begin
          m_pend = ref_result(bus.op_i, bus.a_i, bus.b_i);
          m_left = W + 1;
        end else if (bus.op_i == 3'd4) begin
          m_hi = bus.a_i;
        end else if (bus.op_i == 3'd5) begin
          m_lo = bus.a_i;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        checks = checks + 1;
        if (bus.busy_o !== (m_left != 0) || bus.hi_o !== m_hi || bus.lo_o !== m_lo) begin
          errors = errors + 1;
          $display("FAIL cycle t=%0t: busy=%b hi=%h lo=%h, required busy=%b hi=%h lo=%h",
                   $time, bus.busy_o, bus.hi_o, bus.lo_o, (m_left != 0), m_hi, m_lo);
        end
      end
      if (lit_valid) begin
        checks = checks + 1;
        if (lit_tmo || bus.hi_o !== lit_hi || bus.lo_o !== lit_lo) begin
          errors = errors + 1;
          $display("FAIL %s: hi=%h lo=%h timeout=%b, required hi=%h lo=%h",
                   lit_name, bus.hi_o, bus.lo_o, lit_tmo, lit_hi, lit_lo);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy_o) begin
        tmo = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic lit(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo,
                     input bit tmo);
    lit_name  = name;
    lit_hi    = hi;
    lit_lo    = lo;
    lit_tmo   = tmo;
    lit_valid = 1'b1;
    step();
    lit_valid = 1'b0;
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
    bit tmo;
    issue(op, a, b);
    wait_idle(tmo);
    lit(name, hi, lo, tmo);
  endtask

  function automatic logic [W-1:0] pick_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'd1;
      4:       v = W'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    bit tmo;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    step();
    armed = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    lit("reset", 32'h0, 32'h0, 1'b0);

    run("mult_neg1x2",  3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run("div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_by_zero", 3'd3, 32'd100,       32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run("div_min_m1",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("div_neg_by_zero", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    issue(3'd4, 32'h1234_5678, 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    lit("mthi_mtlo", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    // Ops and operand changes while busy must be ignored
    issue(3'd3, 32'd50, 32'd7);
    repeat (9) step();
    issue(3'd5, 32'hDEAD_BEEF, 32'd3);
    bus.a_i = 32'hFFFF_0000;
    bus.b_i = 32'd1;
    wait_idle(tmo);
    lit("divu_ignore_busy", 32'd1, 32'd7, tmo);

    issue(3'd1, 32'd3, 32'd5);
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lit("abort_by_reset", 32'h0, 32'h0, 1'b0);
    run("multu_reissue", 3'd1, 32'd3, 32'd5, 32'h0, 32'd15);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      issue(3'($urandom_range(0, 7)), pick_val(), pick_val());
      for (int g = $urandom_range(0, 40); g > 0; g--) begin
        bus.a_i = $urandom;
        bus.b_i = $urandom;
        if ($urandom_range(0, 9) == 0) begin
          bus.op_i    = 3'($urandom_range(0, 7));
          bus.start_i = 1'b1;
        end
        step();
        bus.start_i = 1'b0;
      end
    end
    wait_idle(tmo);
    lit("final_idle", m_hi, m_lo, tmo);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register-file read ports: operands arrive from rd0_o/rd1_o.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO.
- Exposes busy_o so the control unit stalls MFHI/MFLO and any new MDU op until results are valid.

Parameters:
- WIDTH, 32, operand and HI/LO width
- CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  issue op_i this cycle
- op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- a_i  input  WIDTH  operand rs (RF rd0_o); multiplicand, dividend, or MTHI/MTLO data
- b_i  input  WIDTH  operand rt (RF rd1_o); multiplier or divisor
- busy_o  output  1  high while an iterative op is in flight
- hi_o  output  WIDTH  HI register
- lo_o  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE, counter 0, busy_o=0, hi_o=0, lo_o=0, internal datapath regs 0. Reset wins over all other inputs, including mid-operation; an aborted op leaves HI/LO=0.
- States: IDLE, CALC, FIX. busy_o = (state != IDLE), registered-state decode only (no combinational path from start_i).
- IDLE:
  - start_i with op 000–011: latch operand magnitudes (abs value for signed ops, raw for unsigned), latch result sign(s) and op, counter=WIDTH-1, go to CALC.
  - start_i with 100 or 101: write a_i to HI or LO at this edge, stay IDLE.
  - 110/111: ignored.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring step on a remainder/quotient pair.
  - Leaves CALC after exactly WIDTH cycles (counter reaches 0); go to FIX.
- FIX, one cycle:
  - Apply sign correction. Product is negated if signs differ (signed only). Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Write HI/LO at the FIX→IDLE edge.
- Latency: start edge to HI/LO update = WIDTH+1 cycles after the issue edge. busy_o is high for WIDTH+1 cycles (33 for default). HI/LO never change while busy.
- start_i while busy_o=1: ignored entirely (all ops, including MTHI/MTLO). Control must stall instead.
- Results:
  - MULT/MULTU: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (b_i=0, any sign): LO = all ones, HI = a_i unchanged. Still takes full latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural magnitude result, no trap).
- Operands are sampled only at the issue edge; later changes on a_i/b_i have no effect.
- hi_o/lo_o are direct register outputs, held between writes.

Test Plan:
- Reset then idle 5 cycles -> busy_o=0, hi_o=lo_o=0.
- MULT a=0xFFFFFFFF b=0x00000002 -> busy_o high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100 b=0 -> LO=0xFFFFFFFF, HI=0x00000064.
- MTHI a=0x12345678, then next cycle MTLO a=0x9ABCDEF0 -> HI/LO updated one edge after each issue, busy_o stays 0.
- Start DIVU 50/7. At cycle 10 issue MTLO 0xDEADBEEF and change a_i/b_i -> ignored; final LO=7, HI=1.
- Start MULTU 3*5, assert rst at cycle 15 -> next edge busy_o=0, HI=LO=0. Re-issue -> LO=15, HI=0 after 33 cycles.
